// File: rtl/glyph_string_render.sv
// Text layer for the pong VGA mixer: renders NUM_CHARS glyphs from a writable
// string buffer through a scaled 5x8 font, two pipeline stages from pixel to display.
module glyph_string_render #(
    parameter int NUM_CHARS    = 8,
    parameter int SCALE        = 5,
    parameter int CHAR_GAP     = 5,
    parameter int BLINK_FRAMES = 30,
    localparam int IW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    start_x,
    input  logic [9:0]    start_y,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          pix_valid,
    input  logic          frame_tick,
    input  logic          blink_en,
    input  logic          load,
    input  logic [IW-1:0] load_idx,
    input  logic [5:0]    load_code,
    output logic          display,
    output logic          display_valid
);
    localparam int GW    = 5 * SCALE;
    localparam int GH    = 8 * SCALE;
    localparam int PITCH = GW + CHAR_GAP;
    localparam int TW    = NUM_CHARS * PITCH - CHAR_GAP;
    localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0] GW11    = 11'(GW);
    localparam logic [10:0] GH11    = 11'(GH);
    localparam logic [10:0] PITCH11 = 11'(PITCH);
    localparam logic [10:0] TW11    = 11'(TW);
    localparam logic [10:0] SCALE11 = 11'(SCALE);
    localparam logic [10:0] NC11    = 11'(NUM_CHARS);
    localparam logic [IW:0] NC_IDX  = (IW+1)'(NUM_CHARS);
    localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

    // Row r of a glyph sits at bits [39-5r -: 5]; the MSB of each row is the leftmost dot.
    function automatic logic glyph_dot(input logic [5:0] code, input logic [2:0] row,
                                       input logic [2:0] col);
        logic [34:0] g;
        logic [39:0] g40;
        logic [5:0]  idx;
        case (code)
            6'd0:  g = 35'b01110_10001_10011_10101_11001_10001_01110;
            6'd1:  g = 35'b00100_01100_00100_00100_00100_00100_01110;
            6'd2:  g = 35'b01110_10001_00001_00010_00100_01000_11111;
            6'd3:  g = 35'b11111_00010_00100_00010_00001_10001_01110;
            6'd4:  g = 35'b00010_00110_01010_10010_11111_00010_00010;
            6'd5:  g = 35'b11111_10000_11110_00001_00001_10001_01110;
            6'd6:  g = 35'b00110_01000_10000_11110_10001_10001_01110;
            6'd7:  g = 35'b11111_00001_00010_00100_01000_01000_01000;
            6'd8:  g = 35'b01110_10001_10001_01110_10001_10001_01110;
            6'd9:  g = 35'b01110_10001_10001_01111_00001_00010_01100;
            6'd10: g = 35'b01110_10001_10001_11111_10001_10001_10001;
            6'd11: g = 35'b11110_10001_10001_11110_10001_10001_11110;
            6'd12: g = 35'b01110_10001_10000_10000_10000_10001_01110;
            6'd13: g = 35'b11100_10010_10001_10001_10001_10010_11100;
            6'd14: g = 35'b11111_10000_10000_11110_10000_10000_11111;
            6'd15: g = 35'b11111_10000_10000_11110_10000_10000_10000;
            6'd16: g = 35'b01110_10001_10000_10111_10001_10001_01111;
            6'd17: g = 35'b10001_10001_10001_11111_10001_10001_10001;
            6'd18: g = 35'b01110_00100_00100_00100_00100_00100_01110;
            6'd19: g = 35'b00111_00010_00010_00010_00010_10010_01100;
            6'd20: g = 35'b10001_10010_10100_11000_10100_10010_10001;
            6'd21: g = 35'b10000_10000_10000_10000_10000_10000_11111;
            6'd22: g = 35'b10001_11011_10101_10101_10001_10001_10001;
            6'd23: g = 35'b10001_10001_11001_10101_10011_10001_10001;
            6'd24: g = 35'b01110_10001_10001_10001_10001_10001_01110;
            6'd25: g = 35'b11110_10001_10001_11110_10000_10000_10000;
            6'd26: g = 35'b01110_10001_10001_10001_10101_10010_01101;
            6'd27: g = 35'b11110_10001_10001_11110_10100_10010_10001;
            6'd28: g = 35'b01111_10000_10000_01110_00001_00001_11110;
            6'd29: g = 35'b11111_00100_00100_00100_00100_00100_00100;
            6'd30: g = 35'b10001_10001_10001_10001_10001_10001_01110;
            6'd31: g = 35'b10001_10001_10001_10001_10001_01010_00100;
            6'd32: g = 35'b10001_10001_10001_10101_10101_10101_01010;
            6'd33: g = 35'b10001_10001_01010_00100_01010_10001_10001;
            6'd34: g = 35'b10001_10001_10001_01010_00100_00100_00100;
            6'd35: g = 35'b11111_00001_00010_00100_01000_10000_11111;
            default: g = '0;
        endcase
        g40 = (code == 6'd62) ? '1 : {g, 5'b00000};
        idx = 6'd39 - ({3'b000, row} * 6'd5) - {3'b000, col};
        glyph_dot = (col <= 3'd4) && g40[idx];
    endfunction

    logic [5:0]  str_buf [NUM_CHARS];
    logic [FW-1:0] fcnt;
    logic        phase;

    logic [10:0] xe, ye, sxe, sye, rx, ry, ci, rem;
    logic        in_box, gap;
    logic [5:0]  code_next;

    assign xe  = {1'b0, x};
    assign ye  = {1'b0, y};
    assign sxe = {1'b0, start_x};
    assign sye = {1'b0, start_y};
    assign rx  = xe - sxe;
    assign ry  = ye - sye;
    assign ci  = rx / PITCH11;
    assign rem = rx % PITCH11;
    assign in_box = (xe >= sxe) && (xe < sxe + TW11) && (ye >= sye) && (ye < sye + GH11);
    assign gap    = (rem >= GW11);
    // Outside the string the slot index runs past the buffer; treat it as blank.
    assign code_next = (ci < NC11) ? str_buf[ci[IW-1:0]] : 6'd63;

    logic        v1, hit_q;
    logic [5:0]  code_q;
    logic [2:0]  col_q, row_q;
    logic        dot;

    assign dot = glyph_dot(code_q, row_q, col_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            v1            <= 1'b0;
            hit_q         <= 1'b0;
            code_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            display       <= 1'b0;
            display_valid <= 1'b0;
        end else begin
            v1            <= pix_valid;
            hit_q         <= in_box & ~gap;
            code_q        <= code_next;
            col_q         <= 3'(rem / SCALE11);
            row_q         <= 3'(ry / SCALE11);
            display_valid <= v1;
            display       <= v1 & hit_q & dot & phase;
        end
    end

    // A load at the same edge as a pixel is invisible to it: stage 1 reads the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHARS; i++) str_buf[i] <= 6'd63;
        end else if (load && ({1'b0, load_idx} < NC_IDX)) begin
            str_buf[load_idx] <= load_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !blink_en) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (frame_tick) begin
            if (fcnt == FLAST) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end
endmodule
